// File: rtl/ysyx_23060208_axi_pkg.sv
// Response codes, size-encoded strobes and FSM encodings shared by the
// dsram responder and its latency counter.
package ysyx_23060208_axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [2:0] STRB_WORD = 3'b100;
   localparam logic [2:0] STRB_HALF = 3'b010;
   localparam logic [2:0] STRB_BYTE = 3'b001;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_WAIT = 2'd1,
      R_RESP = 2'd2
   } r_state_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_WAIT = 2'd2,
      W_RESP = 2'd3
   } w_state_e;

   function automatic logic strb_onehot(input logic [2:0] s);
      return (s == STRB_WORD) || (s == STRB_HALF) || (s == STRB_BYTE);
   endfunction

endpackage

// File: rtl/ysyx_23060208_lat_cnt.sv
// 4-bit loadable down-counter; done_o is high whenever the count sits at zero.
module ysyx_23060208_lat_cnt (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       load_i,
   input  logic [3:0] load_val_i,
   output logic       done_o
);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == 4'd0);

endmodule

// File: rtl/ysyx_23060208_dsram.sv
// AXI4-Lite-style data RAM responder for the EXU dsram port: independent read
// and write FSMs with programmable response latency and size-coded strobes.
module ysyx_23060208_dsram
   import ysyx_23060208_axi_pkg::*;
#(
   parameter int          DATA_WIDTH  = 32,
   parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
   parameter int          DEPTH_WORDS = 4096,
   parameter int          LAT_R       = 1,
   parameter int          LAT_W       = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] dsram_awaddr,
   input  logic                  dsram_awvalid,
   output logic                  dsram_awready,
   input  logic [DATA_WIDTH-1:0] dsram_wdata,
   input  logic [2:0]            dsram_wstrb,
   input  logic                  dsram_wvalid,
   output logic                  dsram_wready,
   output logic [1:0]            dsram_bresp,
   output logic                  dsram_bvalid,
   input  logic                  dsram_bready,
   input  logic [DATA_WIDTH-1:0] dsram_araddr,
   input  logic                  dsram_arvalid,
   output logic                  dsram_arready,
   output logic [DATA_WIDTH-1:0] dsram_rdata,
   output logic [1:0]            dsram_rresp,
   output logic                  dsram_rvalid,
   input  logic                  dsram_rready
);

   localparam int          IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN  = 32'(4 * DEPTH_WORDS);
   localparam logic [3:0]  R_LD  = 4'((LAT_R == 0) ? 0 : LAT_R - 1);
   localparam logic [3:0]  W_LD  = 4'((LAT_W == 0) ? 0 : LAT_W - 1);

   function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                              input logic [31:0] wd,
                                              input logic [2:0]  strb,
                                              input logic [1:0]  off);
      logic [31:0] w;
      w = old_w;
      case (strb)
         STRB_WORD: w = wd;
         STRB_HALF: begin
            if (off[1]) w[31:16] = wd[15:0];
            else        w[15:0]  = wd[15:0];
         end
         STRB_BYTE: w[{off, 3'b000} +: 8] = wd[7:0];
         default:   w = old_w;
      endcase
      return w;
   endfunction

   // Loads are right-aligned so the EXU extender always finds its data at bit 0.
   function automatic logic [31:0] read_align(input logic [31:0] word,
                                              input logic [1:0]  off);
      return word >> {off, 3'b000};
   endfunction

   logic [31:0] mem_q [DEPTH_WORDS];

   r_state_e    r_q, r_d;
   logic [31:0] r_addr_q, r_addr_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;
   logic        r_cnt_load, r_cnt_done, r_cap;
   logic [31:0] r_cap_addr, r_off;
   logic        r_hit;
   logic [IDX_W-1:0] r_idx;

   w_state_e    w_q, w_d;
   logic [31:0] aw_addr_q, aw_addr_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        w_cnt_load, w_cnt_done, mem_we;
   logic [31:0] w_off;
   logic        w_hit, w_misalign, w_err;
   logic [IDX_W-1:0] w_idx;

   ysyx_23060208_lat_cnt u_r_cnt (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (r_cnt_load),
      .load_val_i (R_LD),
      .done_o     (r_cnt_done)
   );

   ysyx_23060208_lat_cnt u_w_cnt (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (w_cnt_load),
      .load_val_i (W_LD),
      .done_o     (w_cnt_done)
   );

   // With zero read latency the capture uses the address still on the AR bus.
   assign r_cap_addr = (r_q == R_IDLE) ? dsram_araddr : r_addr_q;
   assign r_off      = r_cap_addr - ADDR_BASE;
   assign r_hit      = (r_cap_addr >= ADDR_BASE) && (r_off < SPAN);
   assign r_idx      = r_off[IDX_W+1:2];

   always_comb begin
      r_d        = r_q;
      r_addr_d   = r_addr_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      r_cnt_load = 1'b0;
      r_cap      = 1'b0;
      case (r_q)
         R_IDLE: begin
            if (dsram_arvalid) begin
               r_addr_d = dsram_araddr;
               if (LAT_R == 0) begin
                  r_d   = R_RESP;
                  r_cap = 1'b1;
               end else begin
                  r_d        = R_WAIT;
                  r_cnt_load = 1'b1;
               end
            end
         end
         R_WAIT: begin
            if (r_cnt_done) begin
               r_d   = R_RESP;
               r_cap = 1'b1;
            end
         end
         R_RESP: begin
            if (dsram_rready) r_d = R_IDLE;
         end
         default: r_d = R_IDLE;
      endcase
      if (r_cap) begin
         if (r_hit) begin
            rdata_d = read_align(mem_q[r_idx], r_cap_addr[1:0]);
            rresp_d = RESP_OKAY;
         end else begin
            rdata_d = 32'd0;
            rresp_d = RESP_SLVERR;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q      <= R_IDLE;
         r_addr_q <= 32'd0;
         rdata_q  <= 32'd0;
         rresp_q  <= RESP_OKAY;
      end else begin
         r_q      <= r_d;
         r_addr_q <= r_addr_d;
         rdata_q  <= rdata_d;
         rresp_q  <= rresp_d;
      end
   end

   assign w_off      = aw_addr_q - ADDR_BASE;
   assign w_hit      = (aw_addr_q >= ADDR_BASE) && (w_off < SPAN);
   assign w_idx      = w_off[IDX_W+1:2];
   assign w_misalign = ((dsram_wstrb == STRB_HALF) && aw_addr_q[0]) ||
                       ((dsram_wstrb == STRB_WORD) && (aw_addr_q[1:0] != 2'b00));
   assign w_err      = !w_hit || w_misalign || !strb_onehot(dsram_wstrb);

   always_comb begin
      w_d        = w_q;
      aw_addr_d  = aw_addr_q;
      bresp_d    = bresp_q;
      w_cnt_load = 1'b0;
      mem_we     = 1'b0;
      case (w_q)
         W_IDLE: begin
            if (dsram_awvalid) begin
               aw_addr_d = dsram_awaddr;
               w_d       = W_DATA;
            end
         end
         W_DATA: begin
            if (dsram_wvalid) begin
               bresp_d = w_err ? RESP_SLVERR : RESP_OKAY;
               mem_we  = !w_err;
               if (LAT_W == 0) begin
                  w_d = W_RESP;
               end else begin
                  w_d        = W_WAIT;
                  w_cnt_load = 1'b1;
               end
            end
         end
         W_WAIT: begin
            if (w_cnt_done) w_d = W_RESP;
         end
         W_RESP: begin
            if (dsram_bready) w_d = W_IDLE;
         end
         default: w_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_q       <= W_IDLE;
         aw_addr_q <= 32'd0;
         bresp_q   <= RESP_OKAY;
      end else begin
         w_q       <= w_d;
         aw_addr_q <= aw_addr_d;
         bresp_q   <= bresp_d;
      end
   end

   // RAM is not cleared by reset; only the commit strobe is gated by it.
   always_ff @(posedge clk) begin
      if (!rst && mem_we) begin
         mem_q[w_idx] <= lane_merge(mem_q[w_idx], dsram_wdata, dsram_wstrb, aw_addr_q[1:0]);
      end
   end

   assign dsram_arready = (r_q == R_IDLE);
   assign dsram_rvalid  = (r_q == R_RESP);
   assign dsram_rdata   = rdata_q;
   assign dsram_rresp   = rresp_q;
   assign dsram_awready = (w_q == W_IDLE);
   assign dsram_wready  = (w_q == W_DATA);
   assign dsram_bvalid  = (w_q == W_RESP);
   assign dsram_bresp   = bresp_q;

endmodule
